// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational read ports, two write ports,
// optional write-to-read bypass, per-register pending-write scoreboard and exception latch.

module regfile_mp_rdport #(
  parameter int DW     = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]               idx,
  input  logic [DEPTH-1:0][DW-1:0]    mem,
  input  logic [DEPTH-1:0]            busy,
  input  logic                        we0,
  input  logic [AW-1:0]               w0_index,
  input  logic [DW-1:0]               w0_data,
  input  logic                        we1,
  input  logic [AW-1:0]               w1_index,
  input  logic [DW-1:0]               w1_data,
  output logic [DW-1:0]               data,
  output logic                        busy_o
);
  always_comb begin
    data = mem[idx];
    // w1 is checked first so it wins when both write ports hit this index
    if (BYPASS) begin
      if (we1 && (w1_index == idx))      data = w1_data;
      else if (we0 && (w0_index == idx)) data = w0_data;
    end
    if (idx == '0) data = '0;
  end

  assign busy_o = busy[idx];
endmodule

module regfile_mp #(
  parameter int         DW        = 32,
  parameter int         DEPTH     = 32,
  parameter int         AW        = 5,
  parameter int         NUM_READ  = 2,
  parameter bit         BYPASS    = 1'b1,
  parameter logic [7:0] RESET_EXC = 8'h01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_READ*AW-1:0]   rd_index,
  output logic [NUM_READ*DW-1:0]   rd_data,
  output logic [NUM_READ-1:0]      rd_busy,
  input  logic                     w0_en,
  input  logic [AW-1:0]            w0_index,
  input  logic [DW-1:0]            w0_data,
  input  logic                     w1_en,
  input  logic [AW-1:0]            w1_index,
  input  logic [DW-1:0]            w1_data,
  input  logic                     set_en,
  input  logic [AW-1:0]            set_index,
  input  logic [7:0]               exception_in,
  output logic [7:0]               exception
);
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [DEPTH-1:0]         busy;
  logic                     exc_ok, we0, we1, set_ok;

  assign exc_ok = (exception_in == 8'h00);
  assign we0    = w0_en  && (w0_index  != '0) && exc_ok;
  assign we1    = w1_en  && (w1_index  != '0) && exc_ok;
  assign set_ok = set_en && (set_index != '0) && exc_ok;

  // entry 0 is never written after reset, so it stays zero in storage and scoreboard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem       <= '0;
      busy      <= '0;
      exception <= RESET_EXC;
    end else begin
      exception <= exception_in;
      for (int i = 1; i < DEPTH; i++) begin
        if (we1 && (w1_index == AW'(i)))      mem[i] <= w1_data;
        else if (we0 && (w0_index == AW'(i))) mem[i] <= w0_data;

        if (!exc_ok)                                busy[i] <= 1'b0;
        else if (set_ok && (set_index == AW'(i)))   busy[i] <= 1'b1;
        else if ((we0 && (w0_index == AW'(i))) ||
                 (we1 && (w1_index == AW'(i))))     busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    regfile_mp_rdport #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .idx      (rd_index[k*AW +: AW]),
      .mem      (mem),
      .busy     (busy),
      .we0      (we0),
      .w0_index (w0_index),
      .w0_data  (w0_data),
      .we1      (we1),
      .w1_index (w1_index),
      .w1_data  (w1_data),
      .data     (rd_data[k*DW +: DW]),
      .busy_o   (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances driven in lockstep.

module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_index;
  logic [NR*DW-1:0]  rd_data_b, rd_data_n;
  logic [NR-1:0]     busy_b, busy_n;
  logic              w0_en, w1_en, set_en;
  logic [AW-1:0]     w0_index, w1_index, set_index;
  logic [DW-1:0]     w0_data, w1_data;
  logic [7:0]        exception_in, exc_b, exc_n;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .rd_index(rd_index), .rd_data(rd_data_b), .rd_busy(busy_b),
    .w0_en(w0_en), .w0_index(w0_index), .w0_data(w0_data),
    .w1_en(w1_en), .w1_index(w1_index), .w1_data(w1_data),
    .set_en(set_en), .set_index(set_index),
    .exception_in(exception_in), .exception(exc_b));

  regfile_mp #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .rd_index(rd_index), .rd_data(rd_data_n), .rd_busy(busy_n),
    .w0_en(w0_en), .w0_index(w0_index), .w0_data(w0_data),
    .w1_en(w1_en), .w1_index(w1_index), .w1_data(w1_data),
    .set_en(set_en), .set_index(set_index),
    .exception_in(exception_in), .exception(exc_n));

  typedef struct {
    logic w0e; logic [AW-1:0] w0i; logic [DW-1:0] w0d;
    logic w1e; logic [AW-1:0] w1i; logic [DW-1:0] w1d;
    logic se;  logic [AW-1:0] si;  logic [7:0] exc;
    logic [AW-1:0] r0; logic [AW-1:0] r1;
    logic [DW-1:0] e0; logic [DW-1:0] e1; logic [1:0] ebusy; logic [7:0] eexc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d0; logic [DW-1:0] d1; logic [1:0] busy; logic [7:0] exc;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    w0_en = 0; w1_en = 0; set_en = 0; exception_in = 8'h00;
    w0_index = '0; w1_index = '0; set_index = '0; w0_data = '0; w1_data = '0;
  endtask

  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    rd_index = {r1, r0};
  endtask

  function automatic vec_t mk(input logic w0e, input logic [AW-1:0] w0i, input logic [DW-1:0] w0d,
                              input logic w1e, input logic [AW-1:0] w1i, input logic [DW-1:0] w1d,
                              input logic se, input logic [AW-1:0] si, input logic [7:0] exc,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [1:0] eb, input logic [7:0] ee);
    vec_t v;
    v.w0e = w0e; v.w0i = w0i; v.w0d = w0d; v.w1e = w1e; v.w1i = w1i; v.w1d = w1d;
    v.se = se; v.si = si; v.exc = exc; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.e1 = e1; v.ebusy = eb; v.eexc = ee;
    return v;
  endfunction

  initial begin
    exp_t e;
    idle();
    rd(5'd3, 5'd0);

    // reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd0", rd_data_b[31:0], 32'h0);
    chk("rst_busy", {30'd0, busy_b}, 32'h0);
    chk("rst_exc", {24'd0, exc_b}, 32'h01);
    @(negedge clk); rst = 1'b1; #1;
    chk("rel_exc_hold", {24'd0, exc_b}, 32'h01);
    @(posedge clk); #1;
    chk("first_edge_exc", {24'd0, exc_b}, 32'h00);

    //            w0e w0i   w0d           w1e w1i   w1d          se si    exc    r0    r1    e0            e1            busy   exc
    vecs[0]  = mk(1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0, 8'h00, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 8'h00);
    vecs[1]  = mk(1, 5'd0,  32'h5,        0, 5'd0,  32'h0,        0, 5'd0, 8'h00, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 2'b00, 8'h00);
    vecs[2]  = mk(1, 5'd7,  32'h11,       1, 5'd7,  32'h22,       0, 5'd0, 8'h00, 5'd7, 5'd3, 32'h22,       32'hDEADBEEF, 2'b00, 8'h00);
    vecs[3]  = mk(1, 5'd4,  32'hA,        1, 5'd5,  32'hB,        0, 5'd0, 8'h00, 5'd4, 5'd5, 32'hA,        32'hB,        2'b00, 8'h00);
    vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd6, 8'h00, 5'd6, 5'd4, 32'h0,        32'hA,        2'b01, 8'h00);
    vecs[5]  = mk(1, 5'd6,  32'h66,       0, 5'd0,  32'h0,        1, 5'd6, 8'h00, 5'd6, 5'd6, 32'h66,       32'h66,       2'b11, 8'h00);
    vecs[6]  = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h77,       0, 5'd0, 8'h00, 5'd6, 5'd5, 32'h77,       32'hB,        2'b00, 8'h00);
    vecs[7]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0, 8'h00, 5'd0, 5'd6, 32'h0,        32'h77,       2'b00, 8'h00);
    vecs[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd2, 8'h00, 5'd2, 5'd8, 32'h0,        32'h0,        2'b01, 8'h00);
    vecs[9]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd8, 8'h00, 5'd2, 5'd8, 32'h0,        32'h0,        2'b11, 8'h00);
    vecs[10] = mk(1, 5'd2,  32'hFF,       1, 5'd8,  32'hEE,       1, 5'd9, 8'h04, 5'd2, 5'd8, 32'h0,        32'h0,        2'b00, 8'h04);
    vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 8'h00, 5'd9, 5'd7, 32'h0,        32'h22,       2'b00, 8'h00);
    vecs[12] = mk(1, 5'd31, 32'hAAAA5555, 1, 5'd1,  32'h1,        0, 5'd0, 8'h00, 5'd31, 5'd1, 32'hAAAA5555, 32'h1,       2'b00, 8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      w0_en = vecs[i].w0e; w0_index = vecs[i].w0i; w0_data = vecs[i].w0d;
      w1_en = vecs[i].w1e; w1_index = vecs[i].w1i; w1_data = vecs[i].w1d;
      set_en = vecs[i].se; set_index = vecs[i].si; exception_in = vecs[i].exc;
      sb.push_back('{d0: vecs[i].e0, d1: vecs[i].e1, busy: vecs[i].ebusy, exc: vecs[i].eexc});
      @(posedge clk); #1;
      idle();
      rd(vecs[i].r0, vecs[i].r1);
      #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_empty vec=%0d actual=0 expected=1", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_rd0", i), rd_data_b[31:0], e.d0);
        chk($sformatf("v%0d_rd1", i), rd_data_b[63:32], e.d1);
        chk($sformatf("v%0d_busy", i), {30'd0, busy_b}, {30'd0, e.busy});
        chk($sformatf("v%0d_exc", i), {24'd0, exc_b}, {24'd0, e.exc});
        chk($sformatf("v%0d_nob_rd0", i), rd_data_n[31:0], e.d0);
      end
    end

    // same-cycle bypass; write to index 0 must not leak through
    @(negedge clk);
    w1_en = 1; w1_index = 5'd9; w1_data = 32'h1234;
    w0_en = 1; w0_index = 5'd0; w0_data = 32'h5;
    rd(5'd9, 5'd0); #1;
    chk("byp_rd9", rd_data_b[31:0], 32'h1234);
    chk("byp_rd0_zero", rd_data_b[63:32], 32'h0);
    chk("nob_rd9_old", rd_data_n[31:0], 32'h0);
    @(posedge clk); #1; idle(); #1;
    chk("nob_rd9_new", rd_data_n[31:0], 32'h1234);

    // exception disables bypass and suppresses the write
    @(negedge clk);
    exception_in = 8'h03; w0_en = 1; w0_index = 5'd9; w0_data = 32'hBEEF; #1;
    chk("exc_no_byp", rd_data_b[31:0], 32'h1234);
    @(posedge clk); #1; idle(); #1;
    chk("exc_code3", {24'd0, exc_b}, 32'h03);
    chk("exc_no_write", rd_data_b[31:0], 32'h1234);

    // dual-port bypass conflict returns w1; also mark 12 pending
    @(negedge clk);
    w0_en = 1; w0_index = 5'd10; w0_data = 32'h55;
    w1_en = 1; w1_index = 5'd10; w1_data = 32'h66;
    set_en = 1; set_index = 5'd12;
    rd(5'd10, 5'd12); #1;
    chk("byp_conflict", rd_data_b[31:0], 32'h66);
    @(posedge clk); #1; idle(); #1;
    chk("conflict_store", rd_data_n[31:0], 32'h66);
    chk("busy12_set", {31'd0, busy_b[1]}, 32'h1);

    // clear by write only visible after the edge
    @(negedge clk);
    w0_en = 1; w0_index = 5'd12; w0_data = 32'hC;
    rd(5'd12, 5'd10); #1;
    chk("busy12_same_cycle", {31'd0, busy_b[0]}, 32'h1);
    @(posedge clk); #1; idle(); #1;
    chk("busy12_cleared", {31'd0, busy_b[0]}, 32'h0);
    chk("rd12", rd_data_b[31:0], 32'hC);

    // async reset mid-cycle clears storage and scoreboard without a clock edge
    @(negedge clk);
    set_en = 1; set_index = 5'd13;
    @(posedge clk); #1; idle(); rd(5'd13, 5'd3); #1;
    chk("busy13_set", {31'd0, busy_b[0]}, 32'h1);
    rst = 1'b0; #1;
    chk("async_busy", {30'd0, busy_b}, 32'h0);
    chk("async_rd3", rd_data_b[63:32], 32'h0);
    chk("async_exc", {24'd0, exc_b}, 32'h01);
    w0_en = 1; w0_index = 5'd3; w0_data = 32'h99;
    @(posedge clk); #1;
    chk("hold_in_reset", rd_data_n[63:32], 32'h0);
    @(negedge clk); idle(); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_exc", {24'd0, exc_n}, 32'h00);
    chk("post_rst_rd3", rd_data_n[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor of the single-write, dual-read register file.
- Serves the superscalar/dual-issue datapath: NUM_READ combinational read ports, two synchronous write ports, optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard for hazard detection.
- Keeps the WB-stage exception latch behaviour: exception_in suppresses writes and is registered to exception.

Parameters:
- DW, 32, data width per register.
- DEPTH, 32, number of registers; power of two, >=2.
- AW, 5, index width; must equal log2(DEPTH).
- NUM_READ, 2, read port count, 1..8.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- RESET_EXC, 8'h01, exception code driven during/after reset (stall code).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- rd_index  in  NUM_READ*AW  read indices, port k at bits [k*AW +: AW].
- rd_data  out  NUM_READ*DW  read data, port k at bits [k*DW +: DW].
- rd_busy  out  NUM_READ  scoreboard bit for each read index.
- w0_en  in  1  write port 0 enable.
- w0_index  in  AW  write port 0 index.
- w0_data  in  DW  write port 0 data.
- w1_en  in  1  write port 1 enable.
- w1_index  in  AW  write port 1 index.
- w1_data  in  DW  write port 1 data.
- set_en  in  1  mark register pending (issue of producer).
- set_index  in  AW  register to mark pending.
- exception_in  in  8  exception code from previous stage; 0 = none.
- exception  out  8  registered exception code.

Behaviour:
- Reset (rst=0, async):
  - All DEPTH registers cleared to 0.
  - All busy bits cleared.
  - exception = RESET_EXC.
  - rd_data reflects cleared storage immediately.
- Register 0 is hardwired:
  - Reads return 0 regardless of BYPASS or writes.
  - Writes and set_en to index 0 are ignored.
  - rd_busy is never 1 for index 0.
- Reads are combinational, zero latency:
  - BYPASS=0: rd_data = stored value.
  - BYPASS=1: if an effective write to the same index occurs this cycle, rd_data = that write's data; if both ports qualify, w1_data is returned.
- Effective write: wX_en=1, wX_index!=0, exception_in==0.
  - Takes effect at the next posedge; storage is updated only on posedge.
- Write conflict: w0 and w1 to the same index in the same cycle -> w1_data stored.
- exception_in!=0 at posedge:
  - exception <= exception_in.
  - Both writes suppressed; set_en ignored.
  - Entire scoreboard flushed to 0.
  - Bypass also disabled that cycle.
- exception_in==0 at posedge: exception <= 0.
- Scoreboard, per register:
  - Set by set_en to that index.
  - Cleared by any effective write to that index.
  - Same-cycle set and clear on one index: set wins (busy=1).
  - Set of an already-busy register: stays 1.
- rd_busy is the registered busy bit only; a same-cycle clear is not reflected until the next cycle.
- Reset asserted mid-operation clears everything asynchronously, including pending writes.
- No state change occurs while rst=0.
- Simulation-only $display of write activity is permitted; it must not affect synthesis.

Test Plan:
- Reset then read: hold rst=0 two cycles, release; all rd_data=0, rd_busy=0, exception=8'h01; first posedge with exception_in=0 -> exception=0.
- Basic write/read: w0 idx 3 data 0xDEADBEEF; next cycle rd_index[0]=3 -> 0xDEADBEEF; also write idx 0 data 0x5 -> reads 0.
- Dual-write conflict: w0 idx 7 0x11, w1 idx 7 0x22 same cycle -> reg7=0x22; w0 idx 4 0xA, w1 idx 5 0xB -> both stored.
- Bypass: BYPASS=1, w1 idx 9 0x1234, rd_index=9 same cycle -> rd_data=0x1234 combinationally; rebuild BYPASS=0 -> old value 0 until next cycle.
- Scoreboard: set idx 6 -> rd_busy=1 next cycle; w0 idx 6 while set_en idx 6 same cycle -> stays busy; later write without set -> busy 0.
- Exception: busy on idx 2,8; exception_in=8'h04 with w0 idx 2 0xFF -> reg2 unchanged, exception=8'h04, all busy 0; async rst pulse mid-cycle -> storage 0 before next edge.
